// File: rtl/array_multiplier_datapath_if.sv
// Handshake and data bundle between the array-multiplier controller and its
// shift-and-add datapath.
interface array_multiplier_datapath_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               start_tx;
    logic               counted_15;
    logic               ready;
    logic               counted;
    logic               busy;
    logic [2*WIDTH-1:0] product;
    logic               product_valid;

    modport master (
        output multiplicand, multiplier, start_tx, counted_15, ready,
        input  counted, busy, product, product_valid
    );

    modport slave (
        input  multiplicand, multiplier, start_tx, counted_15, ready,
        output counted, busy, product, product_valid
    );
endinterface

// File: rtl/array_multiplier_datapath.sv
// Sequential shift-and-add multiplier datapath: one partial-product row per
// enabled clock, result released to product on the controller's ready.
module array_multiplier_datapath #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    array_multiplier_datapath_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic signed [PW-1:0] a_reg;
    logic signed [PW-1:0] acc;
    logic signed [PW-1:0] product_r;
    logic [WIDTH-1:0]     b_reg;
    logic [CW-1:0]        cnt;
    logic                 active;
    logic                 product_valid_r;

    logic                 counted_w;
    logic                 do_release;
    logic                 do_load;
    logic                 do_step;
    logic [WIDTH-1:0]     b_shift;
    logic signed [PW-1:0] row;
    logic signed [PW-1:0] acc_next;

    function automatic logic signed [PW-1:0] ext_operand(input logic [WIDTH-1:0] v);
        if (SIGNED)
            return {{WIDTH{v[WIDTH-1]}}, v};
        else
            return {{WIDTH{1'b0}}, v};
    endfunction

    // The top row of a two's-complement multiplier carries negative weight.
    function automatic logic signed [PW-1:0] accumulate_row(
        input logic signed [PW-1:0] sum,
        input logic signed [PW-1:0] term,
        input logic                 last_row
    );
        if (SIGNED && last_row)
            return sum - term;
        else
            return sum + term;
    endfunction

    always_comb begin
        counted_w  = active && (cnt == CW'(WIDTH));
        do_release = bus.ready && counted_w;
        do_load    = bus.start_tx && !active && !do_release;
        do_step    = bus.start_tx && active && !bus.counted_15 && (cnt < CW'(WIDTH));
        b_shift    = b_reg >> cnt;
        row        = a_reg << cnt;
        acc_next   = acc;
        if (b_shift[0])
            acc_next = accumulate_row(acc, row, cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active          <= 1'b0;
            cnt             <= '0;
            acc             <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            product_r       <= '0;
            product_valid_r <= 1'b0;
        end else begin
            product_valid_r <= do_release;
            if (do_release) begin
                product_r <= acc;
                active    <= 1'b0;
                cnt       <= '0;
            end else if (do_load) begin
                a_reg  <= ext_operand(bus.multiplicand);
                b_reg  <= bus.multiplier;
                acc    <= '0;
                cnt    <= '0;
                active <= 1'b1;
            end else if (do_step) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.counted       = counted_w;
    assign bus.busy          = active;
    assign bus.product       = product_r;
    assign bus.product_valid = product_valid_r;
endmodule

// File: tb/tb_array_multiplier_datapath.sv
// Directed bench for array_multiplier_datapath: a signed and an unsigned
// instance, results checked by per-instance scoreboard monitors.
module tb_array_multiplier_datapath;
    logic clk;
    logic reset;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] last_prod[2];

    array_multiplier_datapath_if #(.WIDTH(16)) if0 ();
    array_multiplier_datapath_if #(.WIDTH(16)) if1 ();

    array_multiplier_datapath #(.WIDTH(16), .SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .bus(if0)
    );
    array_multiplier_datapath #(.WIDTH(16), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset(reset), .bus(if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit sel, input logic [15:0] a, input logic [15:0] b,
                         input logic st, input logic c15, input logic rdy);
        if (!sel) begin
            if0.multiplicand = a; if0.multiplier = b;
            if0.start_tx = st; if0.counted_15 = c15; if0.ready = rdy;
        end else begin
            if1.multiplicand = a; if1.multiplier = b;
            if1.start_tx = st; if1.counted_15 = c15; if1.ready = rdy;
        end
    endtask

    function automatic logic [31:0] prod_of(input bit sel);
        return sel ? if1.product : if0.product;
    endfunction

    function automatic logic counted_of(input bit sel);
        return sel ? if1.counted : if0.counted;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? if1.busy : if0.busy;
    endfunction

    // Scoreboard monitors: every product_valid pulse must match a queued result.
    always @(negedge clk) begin
        if (reset && if0.product_valid) begin
            if (q0.size() == 0) check("pv_unexpected_s", 32'h1, 32'h0);
            else check("product_s", if0.product, q0.pop_front());
        end
        if (reset && if1.product_valid) begin
            if (q1.size() == 0) check("pv_unexpected_u", 32'h1, 32'h0);
            else check("product_u", if1.product, q1.pop_front());
        end
    end

    // One full operation: load, WIDTH steps (plus optional freeze), optional
    // extra start cycles and early ready, then release with start still high.
    task automatic op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp, input int extra, input bit early, input int frz);
        int k;
        bit got;
        drive(sel, a, b, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        k = 0;
        got = 1'b0;
        while (!got && k < 60) begin
            drive(sel, ~a, b ^ 16'h5A5A, 1'b1, (k >= 3 && k < 3 + frz), (early && k == 5));
            @(posedge clk); #1;
            k++;
            if (k == 2) check("held_product", prod_of(sel), last_prod[sel]);
            if (early && k == 6) begin
                check("early_ready_product", prod_of(sel), last_prod[sel]);
                check("early_ready_busy", {31'b0, busy_of(sel)}, 32'h1);
            end
            if (counted_of(sel)) got = 1'b1;
        end
        check("counted_latency", k, 16 + frz);
        for (int i = 0; i < extra; i++) begin
            drive(sel, a, b, 1'b1, 1'b0, 1'b0);
            @(posedge clk); #1;
            check("counted_hold", {31'b0, counted_of(sel)}, 32'h1);
        end
        if (!sel) q0.push_back(exp); else q1.push_back(exp);
        drive(sel, a, b, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("release_busy", {31'b0, busy_of(sel)}, 32'h0);
        check("release_counted", {31'b0, counted_of(sel)}, 32'h0);
        last_prod[sel] = exp;
        drive(sel, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        last_prod[0] = 32'h0;
        last_prod[1] = 32'h0;
        reset = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst_counted_s", {31'b0, if0.counted}, 32'h0);
        check("rst_busy_s", {31'b0, if0.busy}, 32'h0);
        check("rst_product_s", if0.product, 32'h0);
        check("rst_pv_u", {31'b0, if1.product_valid}, 32'h0);
        check("rst_product_u", if1.product, 32'h0);
        #10 reset = 1'b1;
        @(posedge clk); #1;

        op(1'b0, 16'd3,    16'd5,    32'h0000000F, 0, 1'b0, 0);
        op(1'b0, 16'hFFF9, 16'd6,    32'hFFFFFFD6, 0, 1'b0, 0);
        op(1'b0, 16'h8000, 16'h8000, 32'h40000000, 0, 1'b0, 0);
        op(1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 1'b0, 0);
        op(1'b1, 16'h0000, 16'h1234, 32'h00000000, 0, 1'b0, 0);
        op(1'b0, 16'd3,    16'd5,    32'h0000000F, 5, 1'b1, 0);
        op(1'b0, 16'd7,    16'd9,    32'h0000003F, 0, 1'b0, 3);
        op(1'b0, 16'd12,   16'd12,   32'h00000090, 0, 1'b0, 0);
        op(1'b0, 16'd100,  16'hFFFF, 32'hFFFFFF9C, 0, 1'b0, 0);

        // Abort 3*5 after eight steps.
        drive(1'b0, 16'd3, 16'd5, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        repeat (8) @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        #2;
        check("abort_counted", {31'b0, if0.counted}, 32'h0);
        check("abort_busy", {31'b0, if0.busy}, 32'h0);
        check("abort_product_s", if0.product, 32'h0);
        check("abort_product_u", if1.product, 32'h0);
        last_prod[0] = 32'h0;
        last_prod[1] = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        op(1'b0, 16'd2, 16'd9, 32'h00000012, 0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty_s", q0.size(), 32'h0);
        check("queue_empty_u", q1.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
